// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the SCPU MEM-stage access engine.
// Contents: funct3 load/store codes, FSM state encoding, access-size
// decode helpers, byte-strobe and store-lane replication functions.
package scpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Loads: LB/LBU are byte, LH/LHU are half, every other code is a word.
  function automatic acc_size_t load_size(input logic [2:0] f3);
    acc_size_t sz;
    case (f3)
      F3_LB, F3_LBU: sz = SZ_BYTE;
      F3_LH, F3_LHU: sz = SZ_HALF;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Stores: only SB and SH are narrow, every other code is a word.
  function automatic acc_size_t store_size(input logic [2:0] f3);
    acc_size_t sz;
    case (f3)
      F3_SB:   sz = SZ_BYTE;
      F3_SH:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strobe(input acc_size_t sz, input logic [1:0] off);
    logic [3:0] strb;
    case (sz)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the store operand across all lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_lanes(input acc_size_t sz, input logic [31:0] data);
    logic [31:0] lanes;
    case (sz)
      SZ_BYTE: lanes = {4{data[7:0]}};
      SZ_HALF: lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the byte/halfword addressed by the low
// address bits out of the bus read word and sign- or zero-extends it.
// Ports:
//   rdata     in  32  raw bus read word
//   offset    in  2   ex_addr[1:0] of the load
//   funct3    in  3   load width/sign code
//   load_data out 32  aligned, extended result
module mem_load_align
  import scpu_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
  end

  // Only offset[1] matters for a halfword; alignment is enforced upstream.
  assign sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  load_data = {24'h000000, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  load_data = {16'h0000, sel_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine. Converts the load/store in EX/MEM into
// a data-bus transaction, stalls the upstream pipeline while it runs, then
// presents aligned load data or fault flags for exactly one release cycle.
// Handshake: dbus_req is held high with stable addr/we/wdata/wstrb until a
// cycle in which dbus_ack or dbus_err is high; that cycle completes the
// transfer (dbus_rdata sampled with ack; err wins over ack).
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   ex_valid/ex_mem_read/ex_mem_write/ex_funct3/ex_addr/ex_wdata  EX/MEM slot
//   mem_stall                     hold upstream pipeline
//   load_valid/load_data          load result (release cycle only)
//   misalign/bus_fault/fault_addr fault report (release cycle only)
//   dbus_req/we/addr/wdata/wstrb  bus request side
//   dbus_ack/dbus_rdata/dbus_err  bus response side
// TIMEOUT_CYCLES must fit the counter: 2**CNT_W > TIMEOUT_CYCLES.
module mem_access_unit
  import scpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_fault,
  output logic [31:0] fault_addr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [3:0]       wstrb_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic             load_q;
  logic             mis_q;
  logic             flt_q;

  logic        access;
  acc_size_t   acc_sz;
  logic        acc_aligned;
  logic        timeout;
  logic        bus_done;
  logic        in_done;
  logic [31:0] aligned_data;

  // A set write bit makes the access a store even if the read bit is also set.
  assign access      = ex_valid & (ex_mem_read | ex_mem_write);
  assign acc_sz      = ex_mem_write ? store_size(ex_funct3) : load_size(ex_funct3);
  assign acc_aligned = is_aligned(acc_sz, ex_addr[1:0]);
  assign timeout     = (cnt_q == CNT_LAST);
  assign bus_done    = dbus_ack | dbus_err | timeout;
  assign in_done     = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (access) state_d = acc_aligned ? ST_BUS : ST_DONE;
      end
      ST_BUS: begin
        if (bus_done) state_d = ST_DONE;
      end
      // DONE always returns to IDLE so the still-present EX/MEM instruction
      // is never accepted a second time.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            cnt_q   <= '0;
            addr_q  <= ex_addr;
            we_q    <= ex_mem_write;
            load_q  <= ~ex_mem_write;
            f3_q    <= ex_funct3;
            wstrb_q <= ex_mem_write ? store_strobe(acc_sz, ex_addr[1:0]) : 4'b0000;
            wdata_q <= ex_mem_write ? store_lanes(acc_sz, ex_wdata) : 32'h0;
            rdata_q <= '0;
            mis_q   <= ~acc_aligned;
            flt_q   <= 1'b0;
          end
        end
        ST_BUS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dbus_err || (!dbus_ack && timeout)) begin
            flt_q <= 1'b1;
          end else if (dbus_ack) begin
            rdata_q <= dbus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  mem_load_align u_align (
    .rdata     (rdata_q),
    .offset    (addr_q[1:0]),
    .funct3    (f3_q),
    .load_data (aligned_data)
  );

  always_comb begin
    mem_stall  = (state_q == ST_BUS) | ((state_q == ST_IDLE) & access);
    dbus_req   = (state_q == ST_BUS);
    dbus_we    = dbus_req & we_q;
    dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    dbus_wdata = dbus_req ? wdata_q : 32'h0;
    dbus_wstrb = dbus_req ? wstrb_q : 4'b0000;
    load_valid = in_done & load_q & ~mis_q & ~flt_q;
    load_data  = load_valid ? aligned_data : 32'h0;
    misalign   = in_done & mis_q;
    bus_fault  = in_done & flt_q;
    fault_addr = (misalign | bus_fault) ? addr_q : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors with
// hand-computed results plus sequences for reset, stray ack and non-memory ops.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        mem_stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_fault;
  logic [31:0] fault_addr;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        dbus_err;

  int checks;
  int errors;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_stall(mem_stall), .load_valid(load_valid), .load_data(load_data),
    .misalign(misalign), .bus_fault(bus_fault), .fault_addr(fault_addr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_wait;
    logic        resp;
    logic        err;
    int          exp_stall;
    int          exp_req;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_lv;
    logic [31:0] exp_ldata;
    logic        exp_mis;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] f3, input logic rd, input logic wr, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait,
    input logic resp, input logic err, input int exp_stall, input int exp_req,
    input logic exp_we, input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
    input logic exp_lv, input logic [31:0] exp_ldata, input logic exp_mis,
    input logic exp_flt);
    vec_t v;
    v.f3 = f3; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_wait = ack_wait; v.resp = resp; v.err = err; v.exp_stall = exp_stall;
    v.exp_req = exp_req; v.exp_we = exp_we; v.exp_wstrb = exp_wstrb;
    v.exp_wdata = exp_wdata; v.exp_lv = exp_lv; v.exp_ldata = exp_ldata;
    v.exp_mis = exp_mis; v.exp_flt = exp_flt;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_stall"},  32'(mem_stall), 32'h0);
    chk({tag, " dbus_req"},   32'(dbus_req), 32'h0);
    chk({tag, " dbus_we"},    32'(dbus_we), 32'h0);
    chk({tag, " dbus_addr"},  dbus_addr, 32'h0);
    chk({tag, " dbus_wdata"}, dbus_wdata, 32'h0);
    chk({tag, " dbus_wstrb"}, 32'(dbus_wstrb), 32'h0);
    chk({tag, " load_valid"}, 32'(load_valid), 32'h0);
    chk({tag, " load_data"},  load_data, 32'h0);
    chk({tag, " misalign"},   32'(misalign), 32'h0);
    chk({tag, " bus_fault"},  32'(bus_fault), 32'h0);
    chk({tag, " fault_addr"}, fault_addr, 32'h0);
  endtask

  // driver: present one access, play the bus slave, check the release cycle
  task automatic apply_vec(input int idx, input vec_t v);
    int stall_cnt;
    int req_cnt;
    bit done_seen;
    string t;
    stall_cnt = 0;
    req_cnt   = 0;
    done_seen = 1'b0;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = v.rd; ex_mem_write = v.wr;
    ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wdata;
    dbus_rdata = v.rdata; dbus_ack = 1'b0; dbus_err = 1'b0;
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      #1;
      if (mem_stall) stall_cnt++;
      if (dbus_req) begin
        if (req_cnt == 0) begin
          chk({t, " dbus_addr"}, dbus_addr, {v.addr[31:2], 2'b00});
          chk({t, " dbus_we"}, 32'(dbus_we), 32'(v.exp_we));
          chk({t, " dbus_wstrb"}, 32'(dbus_wstrb), 32'(v.exp_wstrb));
          if (v.exp_we) chk({t, " dbus_wdata"}, dbus_wdata, v.exp_wdata);
        end
        req_cnt++;
        dbus_ack = v.resp && (req_cnt > v.ack_wait);
        dbus_err = v.err && (req_cnt > v.ack_wait);
      end else begin
        dbus_ack = 1'b0;
        dbus_err = 1'b0;
      end
      if (!mem_stall) begin
        done_seen = 1'b1;
        chk({t, " load_valid"}, 32'(load_valid), 32'(v.exp_lv));
        chk({t, " load_data"}, load_data, v.exp_ldata);
        chk({t, " misalign"}, 32'(misalign), 32'(v.exp_mis));
        chk({t, " bus_fault"}, 32'(bus_fault), 32'(v.exp_flt));
        chk({t, " fault_addr"}, fault_addr, (v.exp_mis | v.exp_flt) ? v.addr : 32'h0);
      end
      @(negedge clk);
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s release: no release cycle within 300 cycles", t);
    end
    chk({t, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    chk({t, " req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
    // upstream advances a bubble; the old instruction must not be re-run
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    dbus_ack = 1'b0; dbus_err = 1'b0;
    #1;
    chk({t, " idle_stall"}, 32'(mem_stall), 32'h0);
    chk({t, " idle_req"}, 32'(dbus_req), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'h0;

    //   f3     rd wr addr         wdata        rdata        wt rsp err st rq we strb     wdata        lv ldata        mis flt
    vecs.push_back(mk(3'b010, 1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(3'b000, 1, 0, 32'h103, 32'h0,        32'h80123456, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(3'b100, 1, 0, 32'h103, 32'h0,        32'h80123456, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'h00000080, 0, 0));
    vecs.push_back(mk(3'b101, 1, 0, 32'h102, 32'h0,        32'hABCD1234, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'h0000ABCD, 0, 0));
    vecs.push_back(mk(3'b001, 1, 0, 32'h102, 32'h0,        32'hABCD1234, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'hFFFFABCD, 0, 0));
    vecs.push_back(mk(3'b001, 1, 0, 32'h100, 32'h0,        32'h00018001, 1, 1, 0, 3, 2, 0, 4'b0000, 32'h0,        1, 32'hFFFF8001, 0, 0));
    vecs.push_back(mk(3'b000, 1, 0, 32'h101, 32'h0,        32'h12345678, 2, 1, 0, 4, 3, 0, 4'b0000, 32'h0,        1, 32'h00000056, 0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 32'h101, 32'h000000A5, 32'h0,        3, 1, 0, 5, 4, 1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b001, 0, 1, 32'h102, 32'h1234BEEF, 32'h0,        0, 1, 0, 2, 1, 1, 4'b1100, 32'hBEEFBEEF, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b010, 0, 1, 32'h204, 32'hCAFEF00D, 32'h0,        0, 1, 0, 2, 1, 1, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b010, 1, 0, 32'h102, 32'h0,        32'h11111111, 0, 1, 0, 1, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 0));
    vecs.push_back(mk(3'b001, 0, 1, 32'h103, 32'h0000FFFF, 32'h0,        0, 1, 0, 1, 0, 1, 4'b0000, 32'h0,        0, 32'h0,        1, 0));
    vecs.push_back(mk(3'b101, 1, 0, 32'h101, 32'h0,        32'h22222222, 0, 1, 0, 1, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 0));
    vecs.push_back(mk(3'b010, 1, 0, 32'h300, 32'h0,        32'h33333333, 0, 0, 0, 5, 4, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1));
    vecs.push_back(mk(3'b010, 1, 0, 32'h304, 32'h0,        32'h12345678, 1, 1, 1, 3, 2, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1));
    vecs.push_back(mk(3'b010, 1, 1, 32'h400, 32'h11223344, 32'h99999999, 0, 1, 0, 2, 1, 1, 4'b1111, 32'h11223344, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b011, 1, 0, 32'h408, 32'h0,        32'h87654321, 0, 1, 0, 2, 1, 0, 4'b0000, 32'h0,        1, 32'h87654321, 0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 32'h003, 32'h0000007E, 32'h0,        0, 1, 0, 2, 1, 1, 4'b1000, 32'h7E7E7E7E, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b010, 0, 1, 32'h20C, 32'h00000001, 32'h0,        2, 0, 1, 4, 3, 1, 4'b1111, 32'h00000001, 0, 32'h0,        0, 1));
    vecs.push_back(mk(3'b100, 0, 1, 32'h208, 32'hA1B2C3D4, 32'h0,        0, 1, 0, 2, 1, 1, 4'b1111, 32'hA1B2C3D4, 0, 32'h0,        0, 0));
    vecs.push_back(mk(3'b101, 1, 0, 32'h102, 32'h0,        32'hABCD1234, 3, 1, 0, 5, 4, 0, 4'b0000, 32'h0,        1, 32'h0000ABCD, 0, 0));

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("post_reset");

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // non-memory instruction: no stall, no bus activity
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_addr = 32'h102;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("nonmem%0d stall", k), 32'(mem_stall), 32'h0);
      chk($sformatf("nonmem%0d req", k), 32'(dbus_req), 32'h0);
      @(negedge clk);
    end
    ex_valid = 1'b0;

    // reset in the middle of a bus transaction, then a stray ack
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h500; dbus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrst req_before", 32'(dbus_req), 32'h1);
    rst = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("midrst");
    rst = 1'b1;
    dbus_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("stray load_valid", 32'(load_valid), 32'h0);
    chk("stray load_data", load_data, 32'h0);
    chk("stray req", 32'(dbus_req), 32'h0);
    chk("stray stall", 32'(mem_stall), 32'h0);
    dbus_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("stray2 load_valid", 32'(load_valid), 32'h0);

    // a fresh access after the reset still works
    apply_vec(99, mk(3'b010, 1, 0, 32'h600, 32'h0, 32'h0BADF00D, 0, 1, 0, 2, 1, 0, 4'b0000,
                     32'h0, 1, 32'h0BADF00D, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
